// File: rtl/nexys4_io_pkg.sv
// Board-level constants shared by the Nexys4 I/O front-end blocks.
// Debounce timing is derived from the board oscillator so both stay in step.
package nexys4_io_pkg;

    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int SW_WIDTH    = 16;

    // Cycle count for a given number of milliseconds at the board clock.
    function automatic int cycles_for_ms(input int ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_10MS_CYCLES = cycles_for_ms(10);

endpackage

// File: rtl/sync_ff_vec.sv
// Multi-bit flop-chain synchroniser for slow, independently toggling inputs.
// Bits may resolve on different cycles; downstream filtering absorbs the skew.
module sync_ff_vec #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_val,
    output logic [WIDTH-1:0] sync_val
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= async_val;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_val = stage[SYNC_STAGES-1];

endmodule

// File: rtl/switches_debounce_ctrl.sv
// Slide-switch front end: synchronise, debounce, publish each newly stable value
// as a one-cycle start pulse plus data word, and keep a sticky change flag.
module switches_debounce_ctrl
    import nexys4_io_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_CYCLES,
    parameter int CNT_W         = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             ack_port,
    output logic [WIDTH-1:0] sw_val,
    output logic             sw_valid,
    output logic             sw_changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic             saturated;
    logic             commit;

    sync_ff_vec #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .async_val (sw_raw),
        .sync_val  (sw_sync)
    );

    // Commit only once the candidate has survived the full window and differs
    // from what is already published, so a returning glitch never pulses.
    assign saturated = (sw_sync == cand) && (cnt == CNT_MAX);
    assign commit    = saturated && (cand != sw_val);

    always_ff @(posedge clock) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sw_sync != cand) begin
            cand <= sw_sync;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A commit on the same edge as an acknowledge keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_val     <= '0;
            sw_valid   <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            sw_valid <= commit;
            if (commit) begin
                sw_val     <= cand;
                sw_changed <= 1'b1;
            end else if (ack_port) begin
                sw_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switches_debounce_ctrl.sv
// Self-checking bench: run-length reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_switches_debounce_ctrl;

    localparam int WIDTH  = 16;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] sw_raw = 16'hA5A5;
    logic             ack_port = 1'b0;
    logic [WIDTH-1:0] sw_val;
    logic             sw_valid;
    logic             sw_changed;

    int total = 0;
    int bad   = 0;

    switches_debounce_ctrl #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .ack_port   (ack_port),
        .sw_val     (sw_val),
        .sw_valid   (sw_valid),
        .sw_changed (sw_changed)
    );

    always #5 clock = ~clock;

    // Reference model: the synchronised value seen at an edge is the raw level
    // sampled SYNC edges earlier; a value is published once it has been seen on
    // STABLE+1 consecutive edges (reset counts as an observation of zero).
    logic [WIDTH-1:0] raw_hist [$];
    logic [WIDTH-1:0] run_value = '0;
    int               run_len = 1;
    logic [WIDTH-1:0] exp_val = '0;
    logic             exp_valid = 1'b0;
    logic             exp_changed = 1'b0;

    always @(posedge clock) begin
        logic [WIDTH-1:0] seen;
        if (reset) begin
            raw_hist.delete();
            for (int i = 0; i < SYNC; i++) raw_hist.push_back('0);
            run_value   = '0;
            run_len     = 1;
            exp_val     = '0;
            exp_valid   = 1'b0;
            exp_changed = 1'b0;
        end else begin
            seen = raw_hist.pop_front();
            raw_hist.push_back(sw_raw);
            if (seen == run_value) begin
                if (run_len <= STABLE) run_len++;
            end else begin
                run_value = seen;
                run_len   = 1;
            end
            exp_valid = (run_len >= STABLE + 1) && (seen != exp_val);
            if (exp_valid) begin
                exp_val     = seen;
                exp_changed = 1'b1;
            end else if (ack_port) begin
                exp_changed = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [WIDTH-1:0] act,
                                input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        check_output("model sw_val", sw_val, exp_val);
        check_output("model sw_valid", {15'd0, sw_valid}, {15'd0, exp_valid});
        check_output("model sw_changed", {15'd0, sw_changed}, {15'd0, exp_changed});
    end

    task automatic apply_stimulus(input logic [WIDTH-1:0] raw, input logic ack,
                                  input logic rst);
        sw_raw   = raw;
        ack_port = ack;
        reset    = rst;
    endtask

    task automatic step(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (sw_valid) pulses++;
        end
    endtask

    int p;
    int q;
    logic held_changed;

    initial begin
        // Scenario 1: reset held 3 edges with A5A5, commit on 7th edge after release.
        step(3, p);
        check_output("reset sw_val", sw_val, 16'h0000);
        apply_stimulus(16'hA5A5, 1'b0, 1'b0);
        step(6, p);
        check_output("s1 before commit", sw_val, 16'h0000);
        step(1, p);
        check_output("s1 sw_val", sw_val, 16'hA5A5);
        check_output("s1 sw_valid", {15'd0, sw_valid}, 16'h0001);
        check_output("s1 sw_changed", {15'd0, sw_changed}, 16'h0001);
        step(1, p);
        check_output("s1 pulse width", {15'd0, sw_valid}, 16'h0000);

        // Scenario 4a: acknowledge with no commit clears the flag.
        apply_stimulus(16'hA5A5, 1'b1, 1'b0);
        step(1, p);
        apply_stimulus(16'hA5A5, 1'b0, 1'b0);
        check_output("s4 ack clears", {15'd0, sw_changed}, 16'h0000);

        // Scenario 2: step 0001 -> 8001, single pulse on the 7th edge.
        apply_stimulus(16'h0001, 1'b0, 1'b0);
        step(12, p);
        apply_stimulus(16'h8001, 1'b0, 1'b0);
        step(6, p);
        check_output("s2 before commit", sw_val, 16'h0001);
        step(1, p);
        check_output("s2 sw_val", sw_val, 16'h8001);
        check_output("s2 sw_valid", {15'd0, sw_valid}, 16'h0001);
        step(50, p);
        check_output("s2 no repeat", p[15:0], 16'd0);

        // Scenario 4b: acknowledge on the commit edge leaves the flag set.
        apply_stimulus(16'h00FF, 1'b0, 1'b0);
        step(6, p);
        apply_stimulus(16'h00FF, 1'b1, 1'b0);
        step(1, p);
        apply_stimulus(16'h00FF, 1'b0, 1'b0);
        check_output("s4 commit sw_val", sw_val, 16'h00FF);
        check_output("s4 set wins", {15'd0, sw_changed}, 16'h0001);

        // Scenario 3: short pulse and bounce on a committed zero.
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        step(12, p);
        apply_stimulus(16'h0010, 1'b0, 1'b0);
        step(3, p);
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        step(20, q);
        check_output("s3 glitch pulses", (p + q) & 16'hFFFF, 16'd0);
        check_output("s3 glitch sw_val", sw_val, 16'h0000);
        q = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus((i % 2 == 0) ? 16'h0010 : 16'h0000, 1'b0, 1'b0);
            step(2, p);
            q += p;
        end
        apply_stimulus(16'h0010, 1'b0, 1'b0);
        step(6, p);
        q += p;
        check_output("s3 commit after hold", sw_val, 16'h0000);
        step(10, p);
        q += p;
        check_output("s3 bounce pulses", q[15:0], 16'd1);
        check_output("s3 bounce sw_val", sw_val, 16'h0010);

        // Scenario 6: FFFF for 2 cycles then back to the committed value.
        held_changed = sw_changed;
        apply_stimulus(16'hFFFF, 1'b0, 1'b0);
        step(2, p);
        apply_stimulus(16'h0010, 1'b0, 1'b0);
        step(20, q);
        check_output("s6 no pulse", (p + q) & 16'hFFFF, 16'd0);
        check_output("s6 changed kept", {15'd0, sw_changed}, {15'd0, held_changed});

        // Scenario 5: reset in the middle of a stability count.
        apply_stimulus(16'h1234, 1'b0, 1'b0);
        step(4, p);
        apply_stimulus(16'h1234, 1'b0, 1'b1);
        step(2, p);
        check_output("s5 reset sw_val", sw_val, 16'h0000);
        check_output("s5 reset sw_changed", {15'd0, sw_changed}, 16'h0000);
        apply_stimulus(16'h1234, 1'b0, 1'b0);
        step(6, p);
        check_output("s5 before commit", sw_val, 16'h0000);
        step(1, p);
        check_output("s5 sw_val", sw_val, 16'h1234);
        check_output("s5 sw_valid", {15'd0, sw_valid}, 16'h0001);

        // Randomised phase: bouncing holds, random acks, occasional reset.
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] v;
            int hold;
            v    = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : {12'd0, 4'($urandom_range(0, 3))};
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) begin
                apply_stimulus(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
                step(1, p);
            end
        end
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        step(10, p);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
